// File: rtl/scan_seq_ctrl.sv
// Scan-chain test sequencer: loads a pattern LSB first, pulses functional capture,
// then unloads the response into resp. One test in flight at a time.
module scan_seq_ctrl #(
    parameter int CHAIN_LEN   = 2,
    parameter int CAPTURE_CYC = 1,
    parameter int CNT_W       = 8
) (
    input  logic                 sys_clk,
    input  logic                 rstb,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 scan_out,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] resp
);

    localparam int MAX_CNT = (CHAIN_LEN > CAPTURE_CYC) ? CHAIN_LEN : CAPTURE_CYC;

    if (CHAIN_LEN < 1 || CAPTURE_CYC < 1) begin : g_bad_len
        $error("scan_seq_ctrl: CHAIN_LEN and CAPTURE_CYC must be at least 1");
    end
    if (CNT_W < 1 || (CNT_W < 31 && MAX_CNT >= (1 << CNT_W))) begin : g_bad_cnt_w
        $error("scan_seq_ctrl: CNT_W too small for max(CHAIN_LEN, CAPTURE_CYC)");
    end

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_DONE
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [CHAIN_LEN-1:0] pat_q, pat_n;
    logic [CHAIN_LEN-1:0] shadow_q, shadow_n;
    logic [CHAIN_LEN-1:0] resp_n;

    always_ff @(posedge sys_clk or negedge rstb) begin
        if (!rstb) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pat_q    <= '0;
            shadow_q <= '0;
            resp     <= '0;
            scan_en  <= 1'b0;
            scan_in  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pat_q    <= pat_n;
            shadow_q <= shadow_n;
            resp     <= resp_n;
            // Outputs follow the next state so they line up with the state register.
            scan_en  <= (state_n == S_SHIFT_IN) || (state_n == S_SHIFT_OUT);
            scan_in  <= (state_n == S_SHIFT_IN) && pat_n[0];
            busy     <= (state_n != S_IDLE);
            done     <= (state_n == S_DONE);
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pat_n    = pat_q;
        shadow_n = shadow_q;
        resp_n   = resp;

        if (state != S_IDLE && abort) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_n = S_SHIFT_IN;
                        cnt_n   = '0;
                        pat_n   = pattern;
                    end
                end
                S_SHIFT_IN: begin
                    // pat_q is consumed LSB first; bit 0 is always the next bit to drive.
                    if (cnt == SHIFT_LAST) begin
                        state_n = S_CAPTURE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                        pat_n = pat_q >> 1;
                    end
                end
                S_CAPTURE: begin
                    if (cnt == CAP_LAST) begin
                        state_n = S_SHIFT_OUT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_SHIFT_OUT: begin
                    // After CHAIN_LEN samples the first bit taken has reached bit 0.
                    shadow_n                = shadow_q >> 1;
                    shadow_n[CHAIN_LEN-1]   = scan_out;
                    if (cnt == SHIFT_LAST) begin
                        state_n = S_DONE;
                        cnt_n   = '0;
                        resp_n  = shadow_n;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Bench for scan_seq_ctrl: two instances (2-flop and 5-flop chains) driven by directed
// and random stimulus, checked every cycle against a transaction-offset model.
module tb_scan_seq_ctrl;

    localparam int CL_A = 2, CC_A = 1;
    localparam int CL_B = 5, CC_B = 3;

    logic sys_clk = 1'b0;
    logic rstb    = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic            start_a = 1'b0, abort_a = 1'b0, inv_a = 1'b0;
    logic [CL_A-1:0] pattern_a = '0;
    logic            scan_en_a, scan_in_a, scan_out_a, busy_a, done_a;
    logic [CL_A-1:0] resp_a;
    logic [CL_A-1:0] chain_a = '0;

    logic            start_b = 1'b0, abort_b = 1'b0;
    logic [CL_B-1:0] pattern_b = '0;
    logic            scan_en_b, scan_in_b, scan_out_b, busy_b, done_b;
    logic [CL_B-1:0] resp_b;
    logic [CL_B-1:0] chain_b = '0;

    int n_assert = 0;
    int n_fail   = 0;

    scan_seq_ctrl #(.CHAIN_LEN(CL_A), .CAPTURE_CYC(CC_A), .CNT_W(8)) u_dut_a (
        .sys_clk(sys_clk), .rstb(rstb), .start(start_a), .abort(abort_a),
        .pattern(pattern_a), .scan_en(scan_en_a), .scan_in(scan_in_a),
        .scan_out(scan_out_a), .busy(busy_a), .done(done_a), .resp(resp_a)
    );

    scan_seq_ctrl #(.CHAIN_LEN(CL_B), .CAPTURE_CYC(CC_B), .CNT_W(8)) u_dut_b (
        .sys_clk(sys_clk), .rstb(rstb), .start(start_b), .abort(abort_b),
        .pattern(pattern_b), .scan_en(scan_en_b), .scan_in(scan_in_b),
        .scan_out(scan_out_b), .busy(busy_b), .done(done_b), .resp(resp_b)
    );

    // Chains under test: head at MSB, tail at bit 0; chain A optionally inverts on capture.
    always @(posedge sys_clk) begin
        if (scan_en_a)  chain_a <= {scan_in_a, chain_a[CL_A-1:1]};
        else if (inv_a) chain_a <= ~chain_a;
    end
    assign scan_out_a = chain_a[0];

    always @(posedge sys_clk) begin
        if (scan_en_b) chain_b <= {scan_in_b, chain_b[CL_B-1:1]};
    end
    assign scan_out_b = chain_b[0];

    // Reference model: a test is an offset counter from its acceptance edge.
    bit              ma_busy = 1'b0, ma_inv = 1'b0;
    int              ma_off  = 0;
    logic [CL_A-1:0] ma_pat  = '0, ma_resp = '0;
    bit              mb_busy = 1'b0;
    int              mb_off  = 0;
    logic [CL_B-1:0] mb_pat  = '0, mb_resp = '0;

    always @(posedge sys_clk or negedge rstb) begin
        if (!rstb) begin
            ma_busy <= 1'b0; ma_off <= 0; ma_resp <= '0;
        end else if (!ma_busy) begin
            if (start_a && !abort_a) begin
                ma_busy <= 1'b1; ma_off <= 0; ma_pat <= pattern_a; ma_inv <= inv_a;
            end
        end else if (abort_a || ma_off == 2*CL_A + CC_A) begin
            ma_busy <= 1'b0;
        end else begin
            ma_off <= ma_off + 1;
            // One capture cycle: an inverting chain returns the complement.
            if (ma_off == 2*CL_A + CC_A - 1) ma_resp <= ma_inv ? ~ma_pat : ma_pat;
        end
    end

    always @(posedge sys_clk or negedge rstb) begin
        if (!rstb) begin
            mb_busy <= 1'b0; mb_off <= 0; mb_resp <= '0;
        end else if (!mb_busy) begin
            if (start_b && !abort_b) begin
                mb_busy <= 1'b1; mb_off <= 0; mb_pat <= pattern_b;
            end
        end else if (abort_b || mb_off == 2*CL_B + CC_B) begin
            mb_busy <= 1'b0;
        end else begin
            mb_off <= mb_off + 1;
            if (mb_off == 2*CL_B + CC_B - 1) mb_resp <= mb_pat;
        end
    end

    // {busy, done, scan_en, scan_in} for a test at offset off.
    function automatic logic [3:0] exp_ctl(input bit bsy, input int off, input int cl,
                                           input int cc, input logic [7:0] pat);
        if (!bsy)                return 4'b0000;
        if (off < cl)            return {3'b101, pat[off]};
        if (off < cl + cc)       return 4'b1000;
        if (off < 2*cl + cc)     return 4'b1010;
        return 4'b1100;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_assert = n_assert + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (rstb) begin
            check("cyc_a", {4'h0, busy_a, done_a, scan_en_a, scan_in_a, 6'h0, resp_a},
                  {4'h0, exp_ctl(ma_busy, ma_off, CL_A, CC_A, 8'(ma_pat)), 6'h0, ma_resp});
            check("cyc_b", {4'h0, busy_b, done_b, scan_en_b, scan_in_b, 3'h0, resp_b},
                  {4'h0, exp_ctl(mb_busy, mb_off, CL_B, CC_B, 8'(mb_pat)), 3'h0, mb_resp});
        end
    end

    task automatic launch_a(input logic [CL_A-1:0] pat);
        pattern_a = pat;
        start_a   = 1'b1;
        @(negedge sys_clk);
        start_a   = 1'b0;
    endtask

    // Counts samples until done is seen; -1 if the budget runs out.
    task automatic wait_done(input bit is_b, input int budget, output int lat);
        int i;
        i = 0;
        while (i < budget && !(is_b ? done_b : done_a)) begin
            @(negedge sys_clk);
            i++;
        end
        lat = (is_b ? done_b : done_a) ? i : -1;
    endtask

    initial begin
        int lat, ndone, done_idx;
        logic [5:0] en_tr;

        repeat (2) @(negedge sys_clk);
        check("reset_a", {8'h0, busy_a, done_a, scan_en_a, scan_in_a, 2'b00, resp_a}, 16'h0);
        check("reset_b", {6'h0, busy_b, done_b, scan_en_b, scan_in_b, 1'b0, resp_b}, 16'h0);
        rstb = 1'b1;
        @(negedge sys_clk);

        // Loopback 2'b10: scan_en 1,1,0,1,1 then done in the 6th sample.
        launch_a(2'b10);
        en_tr = '0; done_idx = -1;
        for (int i = 0; i < 6; i++) begin
            en_tr = {en_tr[4:0], scan_en_a};
            if (done_a && done_idx < 0) done_idx = i;
            if (i < 5) @(negedge sys_clk);
        end
        check("en_trace_a", 16'(en_tr), 16'b110110);
        check("lat_a", 16'(done_idx), 16'd5);
        check("resp_loop_a", 16'(resp_a), 16'b10);
        @(negedge sys_clk);
        check("done_width_a", {15'h0, done_a}, 16'h0);

        // Inverting capture.
        inv_a = 1'b1;
        launch_a(2'b01);
        wait_done(1'b0, 40, lat);
        check("lat_inv_a", 16'(lat), 16'd5);
        check("resp_inv_a", 16'(resp_a), 16'b10);
        @(negedge sys_clk);
        check("done_width_inv_a", {15'h0, done_a}, 16'h0);
        inv_a = 1'b0;

        // start during SHIFT_IN is ignored.
        launch_a(2'b01);
        pattern_a = 2'b10;
        start_a   = 1'b1;
        @(negedge sys_clk);
        start_a   = 1'b0;
        wait_done(1'b0, 40, lat);
        check("lat_ignore_a", 16'(lat), 16'd4);
        check("resp_ignore_a", 16'(resp_a), 16'b01);
        ndone = 0;
        repeat (20) begin @(negedge sys_clk); if (done_a) ndone++; end
        check("no_second_done_a", 16'(ndone), 16'd0);

        // Abort in the first capture cycle keeps the previous response.
        launch_a(2'b11);
        wait_done(1'b0, 40, lat);
        check("resp_pre_abort_a", 16'(resp_a), 16'b11);
        @(negedge sys_clk);
        launch_a(2'b00);
        repeat (2) @(negedge sys_clk);
        abort_a = 1'b1;
        @(negedge sys_clk);
        abort_a = 1'b0;
        check("abort_a", {11'h0, busy_a, done_a, scan_en_a, resp_a}, 16'b00011);
        ndone = 0;
        repeat (10) begin @(negedge sys_clk); if (done_a) ndone++; end
        check("abort_no_done_a", 16'(ndone), 16'd0);

        // Asynchronous reset in the first SHIFT_OUT cycle.
        launch_a(2'b00);
        repeat (3) @(negedge sys_clk);
        #2 rstb = 1'b0;
        #1 check("async_rst_a", {8'h0, busy_a, done_a, scan_en_a, scan_in_a, 2'b00, resp_a}, 16'h0);
        repeat (2) @(negedge sys_clk);
        rstb = 1'b1;
        @(negedge sys_clk);
        launch_a(2'b11);
        wait_done(1'b0, 40, lat);
        check("lat_after_rst_a", 16'(lat), 16'd5);
        check("resp_after_rst_a", 16'(resp_a), 16'b11);
        repeat (3) @(negedge sys_clk);

        // Long chain with start held: done 14 periods out, one idle sample between tests.
        pattern_b = 5'b10110;
        start_b   = 1'b1;
        @(negedge sys_clk);
        wait_done(1'b1, 60, lat);
        check("lat_b", 16'(lat), 16'd13);
        check("resp_b", 16'(resp_b), 16'b10110);
        @(negedge sys_clk);
        check("gap_idle_b", {15'h0, busy_b}, 16'h0);
        @(negedge sys_clk);
        check("gap_accept_b", {15'h0, busy_b}, 16'h1);
        wait_done(1'b1, 60, lat);
        check("lat_b2", 16'(lat), 16'd13);
        start_b = 1'b0;
        repeat (20) @(negedge sys_clk);

        // Random traffic on both instances; the per-cycle compare does the checking.
        for (int ph = 0; ph < 2; ph++) begin
            inv_a = (ph == 1);
            repeat (1500) begin
                start_a   = ($urandom_range(0, 2) == 0);
                abort_a   = ($urandom_range(0, 24) == 0);
                pattern_a = CL_A'($urandom);
                start_b   = ($urandom_range(0, 2) == 0);
                abort_b   = ($urandom_range(0, 40) == 0);
                pattern_b = CL_B'($urandom);
                @(negedge sys_clk);
            end
            start_a = 1'b0; abort_a = 1'b0;
            start_b = 1'b0; abort_b = 1'b0;
            repeat (20) @(negedge sys_clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
